// File: rtl/rcu_param.sv
// Receiver control unit for the UART receive path.
// Sequences start-bit verification, data sampling, optional parity and
// 1..2 stop bits. Owns bit counting, parity accumulation and framing checks.
module rcu_param #(
  parameter int unsigned DATA_BITS   = 8,  // 5..9
  parameter int unsigned PARITY_MODE = 0,  // 0 none, 1 even, 2 odd
  parameter int unsigned STOP_BITS   = 1,  // 1 or 2
  parameter int unsigned START_CHECK = 1   // 1 rejects start-bit glitches
) (
  input  logic clk,
  input  logic n_rst,
  input  logic start_bit_detected,
  input  logic sample_tick,
  input  logic serial_in,
  output logic timer_clear,
  output logic enable_timer,
  output logic shift_strobe,
  output logic load_buffer,
  output logic rx_busy,
  output logic parity_error,
  output logic framing_error
);

  localparam int unsigned BIT_CNT_W  = $clog2(DATA_BITS + 1);
  localparam int unsigned STOP_CNT_W = $clog2(STOP_BITS + 1);
  localparam logic        HAS_PARITY  = (PARITY_MODE != 0);
  localparam logic        ODD_PARITY  = (PARITY_MODE == 2);
  localparam logic        CHECK_START = (START_CHECK != 0);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CLR       = 3'd1,
    START_CHK = 3'd2,
    DATA      = 3'd3,
    PARITY    = 3'd4,
    STOP      = 3'd5,
    LOAD      = 3'd6
  } state_t;

  state_t                  state;
  state_t                  next_state;
  logic [BIT_CNT_W-1:0]    bit_cnt;
  logic [STOP_CNT_W-1:0]   stop_cnt;
  logic                    parity_acc;
  logic [BIT_CNT_W-1:0]    bit_cnt_inc;
  logic [STOP_CNT_W-1:0]   stop_cnt_inc;
  logic                    last_bit;
  logic                    last_stop;
  logic                    parity_bad;

  // Counter look-ahead: the tick that completes a field decides the transition.
  assign bit_cnt_inc  = BIT_CNT_W'(bit_cnt + BIT_CNT_W'(1));
  assign stop_cnt_inc = STOP_CNT_W'(stop_cnt + STOP_CNT_W'(1));
  assign last_bit     = (bit_cnt_inc == BIT_CNT_W'(DATA_BITS));
  assign last_stop    = (stop_cnt_inc == STOP_CNT_W'(STOP_BITS));
  assign parity_bad   = ((parity_acc ^ serial_in) != ODD_PARITY);

  // State register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode; start pulses and ticks outside their states are ignored.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start_bit_detected) next_state = CLR;
      end
      CLR: begin
        next_state = START_CHK;
      end
      START_CHK: begin
        if (sample_tick) begin
          next_state = (CHECK_START && serial_in) ? IDLE : DATA;
        end
      end
      DATA: begin
        if (sample_tick && last_bit) begin
          next_state = HAS_PARITY ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (sample_tick) next_state = STOP;
      end
      STOP: begin
        if (sample_tick) begin
          if (!serial_in) begin
            next_state = IDLE;
          end else if (last_stop) begin
            next_state = LOAD;
          end
        end
      end
      LOAD: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Output decode; shift_strobe follows the tick in the same cycle.
  always_comb begin
    timer_clear  = 1'b0;
    enable_timer = 1'b0;
    shift_strobe = 1'b0;
    load_buffer  = 1'b0;
    rx_busy      = (state != IDLE);
    case (state)
      CLR: begin
        timer_clear  = 1'b1;
        enable_timer = 1'b1;
      end
      START_CHK, PARITY, STOP: begin
        enable_timer = 1'b1;
      end
      DATA: begin
        enable_timer = 1'b1;
        shift_strobe = sample_tick;
      end
      LOAD: begin
        load_buffer = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Frame datapath: counters, parity accumulator and sticky error flags.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      bit_cnt       <= '0;
      stop_cnt      <= '0;
      parity_acc    <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      case (state)
        CLR: begin
          bit_cnt       <= '0;
          stop_cnt      <= '0;
          parity_acc    <= 1'b0;
          parity_error  <= 1'b0;
          framing_error <= 1'b0;
        end
        DATA: begin
          if (sample_tick) begin
            bit_cnt    <= bit_cnt_inc;
            parity_acc <= parity_acc ^ serial_in;
          end
        end
        PARITY: begin
          if (sample_tick && parity_bad) parity_error <= 1'b1;
        end
        STOP: begin
          if (sample_tick) begin
            if (!serial_in) begin
              framing_error <= 1'b1;
            end else begin
              stop_cnt <= stop_cnt_inc;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/rcu_param.md
Name: rcu_param

Overview:
- Parametrised receiver control unit for the UART receive path.
- Sequences start-bit verification, data sampling, optional parity check and 1–2 stop bits.
- Drives the bit timer, the shift register strobe and the RX buffer load.
- Does its own bit counting, parity accumulation and stop-bit checking, so there is no external packet_done/framing_error input.

Parameters:
- DATA_BITS, 8: data bits per frame, legal range 5..9.
- PARITY_MODE, 0: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1: stop bits per frame, 1 or 2.
- START_CHECK, 1: 1 = re-sample the start bit at its centre and reject glitches; 0 = no check.

Ports:
- clk  input  1  system clock, rising edge.
- n_rst  input  1  asynchronous active-low reset.
- start_bit_detected  input  1  one-cycle pulse from the start-bit detector.
- sample_tick  input  1  one-cycle pulse from the timer at each bit centre; the first tick after timer_clear is the start-bit centre.
- serial_in  input  1  synchronised serial line.
- timer_clear  output  1  one-cycle pulse that restarts the bit timer.
- enable_timer  output  1  bit timer run enable.
- shift_strobe  output  1  shift-register enable; samples serial_in.
- load_buffer  output  1  one-cycle pulse that loads the RX data buffer.
- rx_busy  output  1  high whenever the FSM is not in IDLE.
- parity_error  output  1  registered, sticky for the frame.
- framing_error  output  1  registered, sticky for the frame.

Behaviour:
- Reset: asynchronous on n_rst low. FSM goes to IDLE; bit counter, stop counter and parity accumulator are cleared; every output is 0. Reset mid-frame aborts the frame with no load.
- FSM states: IDLE, CLR, START_CHK, DATA, PARITY, STOP, LOAD.
- IDLE:
  - On start_bit_detected, go to CLR on the next edge.
  - start_bit_detected is ignored in every other state.
- CLR, exactly one cycle:
  - timer_clear=1 and enable_timer=1.
  - Clears bit counter, stop counter and parity accumulator.
  - Clears parity_error and framing_error.
  - Goes to START_CHK.
- START_CHK, waits for sample_tick:
  - If START_CHECK=1 and serial_in=1 at the tick, treat as a glitch: go to IDLE, no error flag.
  - Otherwise go to DATA.
- DATA:
  - shift_strobe = (state==DATA) & sample_tick. This is Mealy: same cycle as the tick, no added latency.
  - Each tick increments the bit counter and XORs serial_in into the parity accumulator.
  - Bit counter width is $clog2(DATA_BITS+1).
  - On the tick that makes the count equal DATA_BITS, go to PARITY if PARITY_MODE≠0, else to STOP.
- PARITY, on tick:
  - Error condition: (accumulator ^ serial_in) ≠ (PARITY_MODE==2).
  - On error, set parity_error on the next edge.
  - Go to STOP.
- STOP, on each tick:
  - If serial_in=0: set framing_error, go to IDLE; no load and no further stop-bit waiting.
  - Else increment the stop counter; when it reaches STOP_BITS, go to LOAD.
- LOAD, one cycle:
  - load_buffer=1, enable_timer=0.
  - Goes to IDLE.
  - A parity-errored frame is still loaded, with parity_error=1 visible during load_buffer.
- enable_timer: 1 in CLR, START_CHK, DATA, PARITY and STOP; 0 otherwise.
- Latency:
  - start_bit_detected at edge N gives rx_busy=1 and timer_clear=1 in cycle N+1.
  - The final stop tick at edge M gives load_buffer=1 in cycle M+1 and rx_busy=0 from M+2.
- Error flags hold their value after the frame ends and clear only in the next CLR or on reset.
- sample_tick in IDLE, CLR or LOAD is ignored.
- A start_bit_detected pulse arriving in the LOAD cycle is dropped.

Test Plan:
- Defaults (8N1): send 0xA5 LSB-first with stop=1 → exactly 8 shift_strobe pulses coincident with ticks 2..9; load_buffer one cycle after the stop tick; parity_error=0, framing_error=0.
- START_CHECK=1: start_bit_detected, then serial_in=1 at the first tick → IDLE on the next edge; enable_timer=0, no shift_strobe, no load, both error flags 0.
- Defaults: stop bit sampled 0 → framing_error=1 on the next edge, rx_busy=0, no load_buffer; framing_error stays 1 until the next frame's CLR cycle.
- DATA_BITS=7, PARITY_MODE=1: data 0x41 with parity bit 1 → 7 strobes, parity_error=1, load_buffer still pulses once. Same frame with parity bit 0 → parity_error=0.
- STOP_BITS=2: first stop 1, second stop 0 → framing_error=1, no load. Both stops 1 → load_buffer after the second stop tick.
- Assert n_rst low after 3 shift_strobes → all outputs 0 immediately. Then a full 0x3C frame → 8 strobes and a normal load.
